ccff_chain_loader: RTL and testbench

Configuration-chain loader for the fracturable logic tile. It accepts configuration words from the bitstream fetch path over a valid/ready handshake and serialises them LSB-first onto the tile's `ccff_head`. It drives a scan-clock enable so the chain advances exactly `CHAIN_LEN` positions per load, then signals completion. It sits between the fabric-level bitstream streamer and the clock gate feeding each tile's configuration-chain flip-flops.

---
 rtl/ccff_loader_pkg.sv | 15 +
 rtl/ccff_chain_loader_crc16.sv | 30 +++
 rtl/ccff_chain_loader.sv | 134 +++++++++++++
 tb/tb_ccff_chain_loader.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_loader_pkg.sv
// Shared types and constants for the configuration-chain loader.
// FSM encoding plus the readback CRC-16-CCITT polynomial and seed.
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } ccff_state_t;

    localparam logic [15:0] CCFF_CRC_POLY = 16'h1021;
    localparam logic [15:0] CCFF_CRC_INIT = 16'hFFFF;

endpackage

// File: rtl/ccff_chain_loader_crc16.sv
// Serial CRC-16-CCITT, MSB-first; built only with CCFF_LOADER_READBACK_EN.
// Latency: one bit absorbed per enabled edge; no backpressure (en-driven).
// init has priority over en and reseeds the register with 0xFFFF.
`ifdef CCFF_LOADER_READBACK_EN
module ccff_crc16_serial
    import ccff_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] crc
);

    logic feedback;
    assign feedback = crc[15] ^ bit_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= CCFF_CRC_INIT;
        end else if (init) begin
            crc <= CCFF_CRC_INIT;
        end else if (en) begin
            crc <= {crc[14:0], 1'b0} ^ (feedback ? CCFF_CRC_POLY : 16'h0000);
        end
    end

endmodule
`endif

// File: rtl/ccff_chain_loader.sv
// Serialises configuration words LSB-first onto a tile's ccff chain; optional readback CRC (CCFF_LOADER_READBACK_EN).
// Latency: CHAIN_LEN + ceil(CHAIN_LEN/WORD_W) + 2 cycles from start to done, one FETCH bubble per word.
// Backpressure: cfg_ready only in FETCH; a stalled cfg_valid freezes the chain (ccff_clk_en low).
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter  int CHAIN_LEN = 19,
    parameter  int WORD_W    = 8,
    localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              ccff_clk_en,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  bit_count,
    output logic [15:0]       readback_crc
);

    localparam int WCNT_W = $clog2(WORD_W + 1);

    ccff_state_t       state, state_nxt;
    logic [WORD_W-1:0] sreg;
    logic [WCNT_W-1:0] word_bits;
    logic              start_load;
    logic              last_bit;

    assign start_load = (state == ST_IDLE) && start;
    assign last_bit   = (bit_count == CNT_W'(CHAIN_LEN - 1));

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (abort)          state_nxt = ST_IDLE;
                else if (cfg_valid) state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                // Chain length wins over word exhaustion: leftover word bits are dropped.
                if (abort)                            state_nxt = ST_IDLE;
                else if (last_bit)                    state_nxt = ST_DONE;
                else if (word_bits == WCNT_W'(1))     state_nxt = ST_FETCH;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        cfg_ready   = 1'b0;
        ccff_clk_en = 1'b0;
        ccff_head   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            ST_FETCH: begin
                cfg_ready = 1'b1;
                busy      = 1'b1;
            end
            ST_SHIFT: begin
                ccff_clk_en = 1'b1;
                ccff_head   = sreg[0];
                busy        = 1'b1;
            end
            ST_DONE: begin
                done = 1'b1;
                busy = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // The abort edge still counts as a shift: the chain was enabled during that cycle.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            sreg      <= '0;
            word_bits <= '0;
            bit_count <= '0;
        end else begin
            if (start_load) begin
                bit_count <= '0;
            end
            if (state == ST_FETCH && cfg_valid) begin
                sreg      <= cfg_data;
                word_bits <= WCNT_W'(WORD_W);
            end
            if (state == ST_SHIFT) begin
                sreg      <= sreg >> 1;
                word_bits <= word_bits - WCNT_W'(1);
                bit_count <= bit_count + CNT_W'(1);
            end
        end
    end

`ifdef CCFF_LOADER_READBACK_EN
    ccff_crc16_serial u_crc (
        .clk    (prog_clk),
        .rst_n  (prog_reset_n),
        .init   (start_load),
        .en     (ccff_clk_en),
        .bit_in (ccff_tail),
        .crc    (readback_crc)
    );
`else
    logic unused_tail;
    assign unused_tail  = ccff_tail;
    assign readback_crc = 16'h0000;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader with a 19-bit chain model on ccff_head/ccff_tail.
// Expected streams, cycle counts and counts are hand-derived; CRC comes from a reference loop.
module tb_ccff_chain_loader;

    localparam int CHAIN_LEN = 19;
    localparam int WORD_W    = 8;
    localparam int CNT_W     = 5;

    localparam logic [18:0] S1 = {3'b111, 8'h3C, 8'hA5};  // A5,3C,07 in shift order
    localparam logic [18:0] S2 = {3'b110, 8'hC3, 8'h5A};  // 5A,C3,06 in shift order

    logic              prog_clk     = 1'b0;
    logic              prog_reset_n = 1'b0;
    logic              start        = 1'b0;
    logic              abort        = 1'b0;
    logic [WORD_W-1:0] cfg_data     = '0;
    logic              cfg_valid    = 1'b0;
    logic              cfg_ready;
    logic              ccff_head;
    logic              ccff_tail;
    logic              ccff_clk_en;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  bit_count;
    logic [15:0]       readback_crc;

    int n_cmp = 0;
    int n_err = 0;

    logic [18:0] chain  = '0;
    logic        en_s   = 1'b0;
    logic        head_s = 1'b0;
    logic        stream_mem [0:4095];
    int          total_en = 0;

    ccff_chain_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W)) dut (
        .prog_clk     (prog_clk),
        .prog_reset_n (prog_reset_n),
        .start        (start),
        .abort        (abort),
        .cfg_data     (cfg_data),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .ccff_head    (ccff_head),
        .ccff_tail    (ccff_tail),
        .ccff_clk_en  (ccff_clk_en),
        .busy         (busy),
        .done         (done),
        .bit_count    (bit_count),
        .readback_crc (readback_crc)
    );

    always #5 prog_clk = ~prog_clk;

    // Chain model: first bit in ends up at the tail position chain[18].
    assign ccff_tail = chain[18];

    always @(negedge prog_clk) begin
        en_s   = ccff_clk_en;
        head_s = ccff_head;
        if (ccff_clk_en && total_en < 4096) begin
            stream_mem[total_en] = ccff_head;
            total_en++;
        end
    end

    always @(posedge prog_clk) begin
        if (en_s) chain <= {chain[17:0], head_s};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [18:0] get_stream(input int base);
        logic [18:0] s;
        s = '0;
        for (int i = 0; i < 19; i++) begin
            if (base + i < total_en) s[i] = stream_mem[base + i];
        end
        return s;
    endfunction

    function automatic logic [15:0] crc_ref(input logic [18:0] s);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 0; i < 19; i++) begin
            fb = c[15] ^ s[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    function automatic logic [15:0] exp_crc(input logic [18:0] s);
`ifdef CCFF_LOADER_READBACK_EN
        return crc_ref(s);
`else
        return (s == s) ? 16'h0000 : 16'h0000;
`endif
    endfunction

    function automatic logic [15:0] crc_reset_val();
`ifdef CCFF_LOADER_READBACK_EN
        return 16'hFFFF;
`else
        return 16'h0000;
`endif
    endfunction

    // Entered at #1 after an edge with the FSM in IDLE; the start cycle is cycle 1.
    task automatic run_load(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                            input int stall, input int abort_at, input bit start_pulse,
                            output int done_cyc, output int n_en, output int stall_en,
                            output logic [18:0] strm);
        logic [7:0] w [3];
        int  widx, sh0, sh2, stl, cyc, base;
        bit  aborted;
        w[0] = w0; w[1] = w1; w[2] = w2;
        widx = 0; sh0 = 0; sh2 = 0; stl = stall; cyc = 1;
        aborted = 1'b0; done_cyc = 0; stall_en = 0; base = total_en;
        start = 1'b1; cfg_valid = 1'b1; cfg_data = w0;
        for (int k = 0; k < 80; k++) begin
            @(posedge prog_clk); #1;
            cyc++;
            start = 1'b0;
            abort = 1'b0;
            if (aborted) begin
                chk("abort_clk_en", ccff_clk_en, 1'b0);
                chk("abort_busy", busy, 1'b0);
                chk("abort_bit_count", bit_count, 12);
                for (int j = 0; j < 3; j++) begin
                    chk("abort_no_done", done, 1'b0);
                    @(posedge prog_clk); #1;
                end
                break;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (cfg_ready) begin
                if (widx == 1 && stl > 0) begin
                    cfg_valid = 1'b0;
                    stl--;
                    if (ccff_clk_en) stall_en++;
                end else begin
                    cfg_valid = 1'b1;
                    cfg_data  = w[widx];
                    if (widx < 2) widx++; else widx = 3;
                end
            end
            if (ccff_clk_en) begin
                if (widx == 1) begin
                    sh0++;
                    if (start_pulse && sh0 == 3) start = 1'b1;
                end
                if (widx == 2) begin
                    sh2++;
                    if (sh2 == abort_at) begin
                        abort   = 1'b1;
                        aborted = 1'b1;
                    end
                end
            end
        end
        cfg_valid = 1'b0;
        n_en = total_en - base;
        strm = get_stream(base);
    endtask

    task automatic after_done(input string tag, input logic [15:0] crc_exp);
        @(posedge prog_clk); #1;
        chk({tag, "_done_pulse"}, done, 1'b0);
        chk({tag, "_busy_idle"}, busy, 1'b0);
        chk({tag, "_bit_count_held"}, bit_count, 19);
        chk({tag, "_crc"}, readback_crc, crc_exp);
    endtask

    initial begin
        int          dc, ne, se;
        logic [18:0] st, img;
        logic [18:0] cur;

        repeat (2) @(posedge prog_clk);
        #1;
        chk("rst_cfg_ready", cfg_ready, 1'b0);
        chk("rst_ccff_head", ccff_head, 1'b0);
        chk("rst_clk_en", ccff_clk_en, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_bit_count", bit_count, 0);
        chk("rst_crc", readback_crc, crc_reset_val());
        prog_reset_n = 1'b1;
        @(posedge prog_clk); #1;

        // Basic load, valid held high: 19 shifts, done in cycle 24.
        run_load(8'hA5, 8'h3C, 8'h07, 0, 0, 1'b0, dc, ne, se, st);
        chk("t1_head_stream", st, S1);
        chk("t1_clk_en_cycles", ne, 19);
        chk("t1_done_cycle", dc, 24);
        chk("t1_bit_count", bit_count, 19);
        img = {<<{S1}};
        chk("t1_chain_image", chain, img);
        after_done("t1", exp_crc(19'h0));

        // Five-cycle stall before word 2: chain frozen, same final image, crc over S1.
        run_load(8'hA5, 8'h3C, 8'h07, 5, 0, 1'b0, dc, ne, se, st);
        chk("t2_stall_clk_en", se, 0);
        chk("t2_clk_en_cycles", ne, 19);
        chk("t2_done_cycle", dc, 29);
        chk("t2_head_stream", st, S1);
        chk("t2_chain_image", chain, img);
        after_done("t2", exp_crc(S1));

        // start pulsed mid-SHIFT with a second pattern: ignored, normal completion.
        run_load(8'h5A, 8'hC3, 8'h06, 0, 0, 1'b1, dc, ne, se, st);
        chk("t3_head_stream", st, S2);
        chk("t3_clk_en_cycles", ne, 19);
        chk("t3_done_cycle", dc, 24);
        after_done("t3", exp_crc(S1));

        // Reload P1 over P2: readback CRC is that of P2's shifted-out order.
        run_load(8'hA5, 8'h3C, 8'h07, 0, 0, 1'b0, dc, ne, se, st);
        chk("t4_head_stream", st, S1);
        after_done("t4", exp_crc(S2));

        // Abort in the 4th shift of the second word.
        run_load(8'hA5, 8'h3C, 8'h07, 0, 4, 1'b0, dc, ne, se, st);
        chk("t5_abort_no_done", dc, 0);
        chk("t5_clk_en_cycles", ne, 12);

        // Reset mid-SHIFT, then a clean load.
        start = 1'b1; cfg_valid = 1'b1; cfg_data = 8'h5A;
        @(posedge prog_clk); #1;
        start = 1'b0;
        repeat (5) begin
            @(posedge prog_clk); #1;
        end
        chk("t6_pre_rst_shifting", ccff_clk_en, 1'b1);
        prog_reset_n = 1'b0;
        #1;
        chk("t6_rst_cfg_ready", cfg_ready, 1'b0);
        chk("t6_rst_head", ccff_head, 1'b0);
        chk("t6_rst_clk_en", ccff_clk_en, 1'b0);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_done", done, 1'b0);
        chk("t6_rst_bit_count", bit_count, 0);
        chk("t6_rst_crc", readback_crc, crc_reset_val());
        cfg_valid = 1'b0;
        @(posedge prog_clk); #1;
        prog_reset_n = 1'b1;
        @(posedge prog_clk); #1;
        cur = chain;
        run_load(8'hA5, 8'h3C, 8'h07, 0, 0, 1'b0, dc, ne, se, st);
        chk("t6_head_stream", st, S1);
        chk("t6_clk_en_cycles", ne, 19);
        chk("t6_done_cycle", dc, 24);
        chk("t6_bit_count", bit_count, 19);
        after_done("t6", exp_crc({<<{cur}}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
